mem_arbiter: RTL

Two-port arbiter that shares one single-port, synchronous-read word memory between the core's instruction-fetch port and its load/store port. It sits between the rv32i core and the unified program/data RAM, which replaces the combinational instruction ROM. The arbiter grants one request per cycle by round-robin and drives the RAM. It returns read data one cycle later, flags out-of-range accesses, and never starves either requester.

---
 rtl/mem_pkg.sv | 13 +
 rtl/arb_rr2.sv | 18 +
 rtl/mem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified program/data memory path.
package mem_pkg;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick; combinational, one-hot grant (bit0 = fetch, bit1 = data).
// A lone request always wins; under contention the side that did not win last goes.
module arb_rr2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OWN_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between fetch and load/store; grant is same-cycle,
// read data returns one cycle later; losers simply hold their request (max 1 cycle wait).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t      last;
  logic [1:0]  gnt_raw;
  logic [1:0]  gnt;
  logic [31:0] sel_idx;
  logic        any_gnt;
  logic        oor;
  logic        store;
  logic        rsp_if;
  logic        rsp_d;
  logic        rsp_err;

  arb_rr2 u_arb (
    .req  ({d_req, if_req}),
    .last (last),
    .gnt  (gnt_raw)
  );

  // Grants are suppressed while reset is held so the RAM sees no strobe.
  assign gnt     = gnt_raw & {2{rst_n}};
  assign if_gnt  = gnt[0];
  assign d_gnt   = gnt[1];
  assign any_gnt = |gnt;
  assign store   = gnt[1] & d_we;

  always_comb begin
    sel_idx = word_idx(32'(gnt[1] ? d_addr : if_addr));
  end

  assign oor       = sel_idx >= 32'(DEPTH);
  assign mem_en    = any_gnt & ~oor;
  assign mem_we    = (mem_en & store) ? d_be : '0;
  assign mem_addr  = mem_en ? sel_idx[MEM_AW-1:0] : '0;
  assign mem_wdata = (mem_en & store) ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= OWN_D;
      rsp_if  <= 1'b0;
      rsp_d   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      rsp_if  <= gnt[0];
      rsp_d   <= gnt[1] & ~d_we;
      rsp_err <= any_gnt & oor;
      if (any_gnt) begin
        last <= gnt[1] ? OWN_D : OWN_IF;
      end
    end
  end

  // An out-of-range store still reports err, but never a load-data valid.
  assign if_rvalid = rsp_if;
  assign d_rvalid  = rsp_d;
  assign err       = rsp_err;
  assign if_rdata  = (rsp_if & ~rsp_err) ? mem_rdata : '0;
  assign d_rdata   = (rsp_d & ~rsp_err) ? mem_rdata : '0;

endmodule
